// File: rtl/if_fetch_stage_if.sv
// Bus bundle between the fetch stage and its environment (hazard unit, execute
// redirect, instruction memory, IF/ID consumer, performance counters).
interface if_fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            ifid_valid;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_pc4;
    logic [XLEN-1:0] ifid_instr;
    logic            misalign;
    logic [31:0]     fetch_cnt;
    logic [31:0]     bubble_cnt;

    // The fetch stage drives the bus; the surrounding pipeline/memory listens.
    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr,
               misalign, fetch_cnt, bubble_cnt
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr,
               misalign, fetch_cnt, bubble_cnt
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HOLD control and IF/ID register.
// Define IF_PERF_CNT_EN to build the fetch/bubble performance counters.
module if_fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    if_fetch_stage_if.master bus
);
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] pc_plus4;
    logic            advance;
    logic            bubble;

    assign pc_plus4 = pc_q + {{(XLEN-3){1'b0}}, 3'b100};

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        misalign_d   = 1'b0;
        advance      = 1'b0;
        bubble       = 1'b0;

        if (bus.redirect_valid) begin
            // Flush only invalidates; the payload fields keep their old contents.
            pc_d         = {bus.redirect_pc[XLEN-1:2], 2'b00};
            ifid_valid_d = 1'b0;
            misalign_d   = |bus.redirect_pc[1:0];
            state_d      = RUN;
            bubble       = 1'b1;
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_d = RUN;
                    bubble  = 1'b1;
                end
                RUN, HOLD: begin
                    if (bus.stall) begin
                        state_d = HOLD;
                        bubble  = 1'b1;
                    end else begin
                        state_d      = RUN;
                        pc_d         = pc_plus4;
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = pc_q;
                        ifid_pc4_d   = pc_plus4;
                        ifid_instr_d = bus.imem_rdata;
                        advance      = 1'b1;
                    end
                end
                default: state_d = BOOT;
            endcase
            if (state_q == BOOT) bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= '0;
            misalign_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            misalign_q   <= misalign_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (advance) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            if (bubble)  bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign bus.fetch_cnt  = fetch_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt     = advance ^ bubble;
    assign bus.fetch_cnt  = '0;
    assign bus.bubble_cnt = '0;
`endif

    assign bus.imem_addr  = pc_q;
    assign bus.ifid_valid = ifid_valid_q;
    assign bus.ifid_pc    = ifid_pc_q;
    assign bus.ifid_pc4   = ifid_pc4_q;
    assign bus.ifid_instr = ifid_instr_q;
    assign bus.misalign   = misalign_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, boot, stall, redirect, misalign,
// PC wrap and asynchronous mid-run reset, with hand-computed expectations.
module tb_if_fetch_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_fetch = 0;
    int   exp_bubble = 0;

    if_fetch_stage_if #(.XLEN(32)) bus ();

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory model: a distinct word derived from each address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef IF_PERF_CNT_EN
        check({tag, ".fetch_cnt"},  bus.fetch_cnt,  32'(exp_fetch));
        check({tag, ".bubble_cnt"}, bus.bubble_cnt, 32'(exp_bubble));
`else
        check({tag, ".fetch_cnt"},  bus.fetch_cnt,  32'd0);
        check({tag, ".bubble_cnt"}, bus.bubble_cnt, 32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] next_addr);
        check({tag, ".valid"}, {31'd0, bus.ifid_valid}, {31'd0, v});
        check({tag, ".pc"},    bus.ifid_pc,    pc);
        check({tag, ".pc4"},   bus.ifid_pc4,   pc + 32'd4);
        check({tag, ".instr"}, bus.ifid_instr, mem_word(pc));
        check({tag, ".addr"},  bus.imem_addr,  next_addr);
    endtask

    initial begin
        rst                = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        #12;
        check("rst.addr",     bus.imem_addr, 32'h0);
        check("rst.valid",    {31'd0, bus.ifid_valid}, 32'd0);
        check("rst.pc",       bus.ifid_pc, 32'h0);
        check("rst.pc4",      bus.ifid_pc4, 32'h0);
        check("rst.instr",    bus.ifid_instr, 32'h0);
        check("rst.misalign", {31'd0, bus.misalign}, 32'd0);
        check_cnt("rst");

        // Boot cycle, then sequential fetch from 0.
        rst = 1'b1;
        step(); exp_bubble++;
        check("boot.valid", {31'd0, bus.ifid_valid}, 32'd0);
        check("boot.addr",  bus.imem_addr, 32'h0);
        step(); exp_fetch++;
        check_ifid("c2", 1'b1, 32'h0, 32'h4);
        step(); exp_fetch++;
        check_ifid("c3", 1'b1, 32'h4, 32'h8);
        step(); exp_fetch++;
        step(); exp_fetch++;
        check_ifid("c5", 1'b1, 32'hC, 32'h10);
        check_cnt("c5");

        // Three stall cycles at pc 0x10.
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); exp_bubble++;
            check_ifid("stall", 1'b1, 32'hC, 32'h10);
        end
        check_cnt("stall");
        bus.stall = 1'b0;
        step(); exp_fetch++;
        check_ifid("unstall", 1'b1, 32'h10, 32'h14);

        // Redirect beats a concurrent stall; payload survives the flush.
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step(); exp_bubble++;
        check_ifid("redir", 1'b0, 32'h10, 32'h200);
        check("redir.misalign", {31'd0, bus.misalign}, 32'd0);
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        step(); exp_fetch++;
        check_ifid("redir.adv", 1'b1, 32'h200, 32'h204);

        // Misaligned redirect: aligned PC, one-cycle misalign pulse.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        step(); exp_bubble++;
        check("mis.addr",     bus.imem_addr, 32'h100);
        check("mis.misalign", {31'd0, bus.misalign}, 32'd1);
        check("mis.valid",    {31'd0, bus.ifid_valid}, 32'd0);
        bus.redirect_valid = 1'b0;
        step(); exp_fetch++;
        check("mis.clear", {31'd0, bus.misalign}, 32'd0);
        check_ifid("mis.adv", 1'b1, 32'h100, 32'h104);

        // PC wrap at the top of the address space.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step(); exp_bubble++;
        check("wrap.addr0", bus.imem_addr, 32'hFFFF_FFFC);
        bus.redirect_valid = 1'b0;
        step(); exp_fetch++;
        check("wrap.pc",   bus.ifid_pc,   32'hFFFF_FFFC);
        check("wrap.pc4",  bus.ifid_pc4,  32'h0000_0000);
        check("wrap.addr", bus.imem_addr, 32'h0000_0000);
        check_cnt("wrap");

        // Run up to pc 0x40, then reset asynchronously between edges.
        for (int i = 0; i < 16; i++) begin
            step(); exp_fetch++;
        end
        check_ifid("run40", 1'b1, 32'h3C, 32'h40);
        check_cnt("run40");
        #2 rst = 1'b0;
        #1;
        check("arst.addr",  bus.imem_addr, 32'h0);
        check("arst.valid", {31'd0, bus.ifid_valid}, 32'd0);
        check("arst.pc",    bus.ifid_pc, 32'h0);
        check("arst.instr", bus.ifid_instr, 32'h0);
        exp_fetch  = 0;
        exp_bubble = 0;
        check_cnt("arst");

        // Redirect during BOOT is taken and the stage still proceeds to RUN.
        @(negedge clk);
        rst                = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        step(); exp_bubble++;
        check("bootredir.addr",  bus.imem_addr, 32'h80);
        check("bootredir.valid", {31'd0, bus.ifid_valid}, 32'd0);
        bus.redirect_valid = 1'b0;
        step(); exp_fetch++;
        check_ifid("bootredir.adv", 1'b1, 32'h80, 32'h84);
        check_cnt("bootredir");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
